// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared constants and FSM encodings for the ALU command driver
//
// Contents:
//   DATA_W   operand/result width of the ALU datapath
//   OP_*     3-bit ALU opcode map
//   state_t  driver FSM states (IDLE, DRIVE, RESP), 2-bit encoding
package alu_pkg;

  localparam int DATA_W = 8;

  localparam logic [2:0] OP_NOT  = 3'b000;
  localparam logic [2:0] OP_OR   = 3'b001;
  localparam logic [2:0] OP_XOR  = 3'b010;
  localparam logic [2:0] OP_AND  = 3'b011;
  localparam logic [2:0] OP_MUL  = 3'b100;
  localparam logic [2:0] OP_ADD  = 3'b101;
  localparam logic [2:0] OP_SUB  = 3'b110;
  localparam logic [2:0] OP_ZERO = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_RESP  = 2'd2
  } state_t;

endpackage

// File: rtl/alu_cmd_driver_if.sv
// rtl/alu_cmd_driver_if.sv - command and response handshake bundle for alu_cmd_driver
//
// Signals:
//   cmd_valid / cmd_ready          command handshake
//   cmd_op, cmd_a, cmd_b           opcode and operands
//   cmd_use_acc                    1: operand A comes from the accumulator
//   rsp_valid / rsp_ready          response handshake
//   rsp_data, rsp_zero             captured result and its zero flag
// Modports:
//   master  issues commands, consumes responses
//   slave   the driver block
interface alu_cmd_driver_if;
  import alu_pkg::*;

  logic              cmd_valid;
  logic              cmd_ready;
  logic [2:0]        cmd_op;
  logic [DATA_W-1:0] cmd_a;
  logic [DATA_W-1:0] cmd_b;
  logic              cmd_use_acc;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_zero;

  modport master (
    output cmd_valid, cmd_op, cmd_a, cmd_b, cmd_use_acc, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data, rsp_zero
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_a, cmd_b, cmd_use_acc, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data, rsp_zero
  );

endinterface

// File: rtl/alu_cmd_driver.sv
// rtl/alu_cmd_driver.sv - sequential initiator for the 8-bit combinational ALU
//
// Accepts one command at a time, drives registered operands/opcode into the
// ALU, waits SETTLE_CYCLES edges, captures alu_out into the response and the
// accumulator, then holds the response until it is accepted.
//
// Parameters:
//   SETTLE_CYCLES  cycles operands are held on the ALU before capture (1..15)
//   ACC_RESET_VAL  accumulator value after reset
// Ports:
//   clk, rst_n     clock (rising edge), synchronous active-low reset
//   bus            alu_cmd_driver_if.slave: cmd_* in, rsp_* out
//   alu_a, alu_b   registered operands to the ALU
//   alu_opcode     registered opcode to the ALU
//   alu_out        combinational ALU result
//   busy           high whenever the FSM is not IDLE
//   done_count     response handshake counter (only with ALU_CMD_COUNT_EN)
// Optional feature macro: ALU_CMD_COUNT_EN
module alu_cmd_driver
  import alu_pkg::*;
#(
  parameter int                SETTLE_CYCLES = 1,
  parameter logic [DATA_W-1:0] ACC_RESET_VAL = 8'h00
) (
  input  logic              clk,
  input  logic              rst_n,
  alu_cmd_driver_if.slave   bus,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [2:0]        alu_opcode,
  input  logic [DATA_W-1:0] alu_out,
  output logic              busy
`ifdef ALU_CMD_COUNT_EN
  ,
  output logic [15:0]       done_count
`endif
);

  // Counter is loaded with SETTLE_CYCLES-1 so capture lands exactly
  // SETTLE_CYCLES edges after the accepting edge.
  localparam logic [3:0] SETTLE_INIT = 4'(SETTLE_CYCLES - 1);

  state_t            state;
  logic [3:0]        settle_cnt;
  logic [DATA_W-1:0] acc;
  logic [DATA_W-1:0] rsp_data_q;
  logic              rsp_zero_q;
  logic              cmd_ready_q;
  logic              rsp_valid_q;
  logic              busy_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      settle_cnt  <= '0;
      acc         <= ACC_RESET_VAL;
      alu_a       <= '0;
      alu_b       <= '0;
      alu_opcode  <= '0;
      rsp_data_q  <= '0;
      rsp_zero_q  <= 1'b0;
      cmd_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.cmd_valid && cmd_ready_q) begin
            alu_a       <= bus.cmd_use_acc ? acc : bus.cmd_a;
            alu_b       <= bus.cmd_b;
            alu_opcode  <= bus.cmd_op;
            settle_cnt  <= SETTLE_INIT;
            state       <= ST_DRIVE;
            cmd_ready_q <= 1'b0;
            busy_q      <= 1'b1;
          end
        end
        ST_DRIVE: begin
          if (settle_cnt == 4'd0) begin
            rsp_data_q  <= alu_out;
            acc         <= alu_out;
            rsp_zero_q  <= (alu_out == '0);
            state       <= ST_RESP;
            rsp_valid_q <= 1'b1;
          end else begin
            settle_cnt <= settle_cnt - 4'd1;
          end
        end
        ST_RESP: begin
          // Response and operands stay frozen until the consumer takes it;
          // no new command is accepted in the meantime.
          if (bus.rsp_ready) begin
            state       <= ST_IDLE;
            rsp_valid_q <= 1'b0;
            cmd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
          end
        end
        default: begin
          state       <= ST_IDLE;
          rsp_valid_q <= 1'b0;
          cmd_ready_q <= 1'b1;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.cmd_ready = cmd_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_zero  = rsp_zero_q;
  assign busy          = busy_q;

`ifdef ALU_CMD_COUNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      done_count <= '0;
    end else if (rsp_valid_q && bus.rsp_ready) begin
      done_count <= done_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_cmd_driver.sv
// tb/tb_alu_cmd_driver.sv - scoreboard bench for alu_cmd_driver (settle 1 and settle 4 instances)
module tb_alu_cmd_driver;
  import alu_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_cmd_driver_if b1 ();
  alu_cmd_driver_if b4 ();

  logic [7:0] a1, bb1, o1, a4, bb4, o4;
  logic [2:0] op1, op4;
  logic       busy1, busy4;
`ifdef ALU_CMD_COUNT_EN
  logic [15:0] dc1, dc4;
`endif

  alu_cmd_driver #(.SETTLE_CYCLES(1), .ACC_RESET_VAL(8'h00)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .bus(b1),
    .alu_a(a1), .alu_b(bb1), .alu_opcode(op1), .alu_out(o1), .busy(busy1)
`ifdef ALU_CMD_COUNT_EN
    , .done_count(dc1)
`endif
  );

  alu_cmd_driver #(.SETTLE_CYCLES(4), .ACC_RESET_VAL(8'h00)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .bus(b4),
    .alu_a(a4), .alu_b(bb4), .alu_opcode(op4), .alu_out(o4), .busy(busy4)
`ifdef ALU_CMD_COUNT_EN
    , .done_count(dc4)
`endif
  );

  // Combinational ALU the drivers talk to.
  function automatic logic [7:0] alu_model(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = a * b;
    case (op)
      3'b000:  return ~a;
      3'b001:  return a | b;
      3'b010:  return a ^ b;
      3'b011:  return a & b;
      3'b100:  return p[7:0];
      3'b101:  return a + b;
      3'b110:  return a - b;
      default: return 8'h00;
    endcase
  endfunction

  assign o1 = alu_model(op1, a1, bb1);
  assign o4 = alu_model(op4, a4, bb4);

  typedef struct {
    logic [7:0] data;
    logic       zero;
    int         cyc;
  } exp_t;

  exp_t q1[$];
  exp_t q4[$];
  exp_t e1, e4;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int hs1 = 0, hs4 = 0;
  logic pv1 = 1'b0, pv4 = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitors: compare each newly presented response against the scoreboard.
  always @(negedge clk) begin
    if (rst_n && b1.rsp_valid && !pv1) begin
      if (q1.size() == 0) begin
        checks++; errors++;
        $display("FAIL d1_unexpected_rsp actual=%0h required=none", b1.rsp_data);
      end else begin
        e1 = q1.pop_front();
        check("d1_rsp_data", 32'(b1.rsp_data), 32'(e1.data));
        check("d1_rsp_zero", 32'(b1.rsp_zero), 32'(e1.zero));
        check("d1_latency_cycle", cyc, e1.cyc);
      end
    end
    if (!rst_n) hs1 = 0;
    else if (b1.rsp_valid && b1.rsp_ready) hs1++;
    pv1 = rst_n ? b1.rsp_valid : 1'b0;
  end

  always @(negedge clk) begin
    if (rst_n && b4.rsp_valid && !pv4) begin
      if (q4.size() == 0) begin
        checks++; errors++;
        $display("FAIL d4_unexpected_rsp actual=%0h required=none", b4.rsp_data);
      end else begin
        e4 = q4.pop_front();
        check("d4_rsp_data", 32'(b4.rsp_data), 32'(e4.data));
        check("d4_rsp_zero", 32'(b4.rsp_zero), 32'(e4.zero));
        check("d4_latency_cycle", cyc, e4.cyc);
      end
    end
    if (!rst_n) hs4 = 0;
    else if (b4.rsp_valid && b4.rsp_ready) hs4++;
    pv4 = rst_n ? b4.rsp_valid : 1'b0;
  end

  function automatic logic rdy(input int d);
    return (d == 1) ? b1.cmd_ready : b4.cmd_ready;
  endfunction

  // Waits (bounded) for the response handshake; returns just after that edge.
  task automatic wait_hs(input int d);
    int n;
    n = 0;
    while (!((d == 1) ? (b1.rsp_valid && b1.rsp_ready) : (b4.rsp_valid && b4.rsp_ready)) && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 50) begin
      checks++; errors++;
      $display("FAIL d%0d_rsp_timeout actual=no_handshake required=handshake", d);
    end else begin
      @(posedge clk); #1;
    end
  endtask

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input int d, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                      input logic use_acc, input logic [7:0] exp_data, input logic exp_zero,
                      input bit push, input bit wait_rsp);
    int n;
    n = 0;
    while (!rdy(d) && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 50) begin
      checks++; errors++;
      $display("FAIL d%0d_cmd_ready_timeout actual=0 required=1", d);
    end
    if (d == 1) begin
      b1.cmd_valid = 1'b1; b1.cmd_op = op; b1.cmd_a = a; b1.cmd_b = b; b1.cmd_use_acc = use_acc;
      if (push) q1.push_back('{data: exp_data, zero: exp_zero, cyc: cyc + 1 + 1});
    end else begin
      b4.cmd_valid = 1'b1; b4.cmd_op = op; b4.cmd_a = a; b4.cmd_b = b; b4.cmd_use_acc = use_acc;
      if (push) q4.push_back('{data: exp_data, zero: exp_zero, cyc: cyc + 1 + 4});
    end
    @(posedge clk); #1;
    b1.cmd_valid = 1'b0;
    b4.cmd_valid = 1'b0;
    if (wait_rsp) wait_hs(d);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    b1.cmd_valid = 0; b1.cmd_op = 0; b1.cmd_a = 0; b1.cmd_b = 0; b1.cmd_use_acc = 0; b1.rsp_ready = 1;
    b4.cmd_valid = 0; b4.cmd_op = 0; b4.cmd_a = 0; b4.cmd_b = 0; b4.cmd_use_acc = 0; b4.rsp_ready = 1;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_alu_a", 32'(a1), 32'h0);
    check("rst_alu_b", 32'(bb1), 32'h0);
    check("rst_alu_opcode", 32'(op1), 32'h0);
    check("rst_rsp_data", 32'(b1.rsp_data), 32'h0);
    check("rst_rsp_zero", 32'(b1.rsp_zero), 32'h0);
    check("rst_cmd_ready", 32'(b1.cmd_ready), 32'h1);
    check("rst_rsp_valid", 32'(b1.rsp_valid), 32'h0);
    check("rst_busy", 32'(busy1), 32'h0);
    check("rst_d4_cmd_ready", 32'(b4.cmd_ready), 32'h1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic ops on the settle-1 instance.
    send(1, OP_ADD, 8'h3C, 8'h05, 1'b0, 8'h41, 1'b0, 1, 1);
    check("add_cmd_ready_after_hs", 32'(b1.cmd_ready), 32'h1);
    check("add_busy_after_hs", 32'(busy1), 32'h0);
    check("add_rsp_valid_after_hs", 32'(b1.rsp_valid), 32'h0);
    send(1, OP_SUB, 8'h05, 8'h06, 1'b0, 8'hFF, 1'b0, 1, 1);
    send(1, OP_MUL, 8'h10, 8'h10, 1'b0, 8'h00, 1'b1, 1, 1);

    // Accumulator chaining.
    send(1, OP_ADD, 8'h01, 8'h02, 1'b0, 8'h03, 1'b0, 1, 1);
    send(1, OP_ADD, 8'hAA, 8'h04, 1'b1, 8'h07, 1'b0, 1, 1);
    send(1, OP_NOT, 8'hAA, 8'h55, 1'b1, 8'hF8, 1'b0, 1, 1);

    // Backpressure: response held, extra command pulses ignored.
    b1.rsp_ready = 1'b0;
    send(1, OP_XOR, 8'h0F, 8'hFF, 1'b0, 8'hF0, 1'b0, 1, 0);
    check("bp_busy_in_drive", 32'(busy1), 32'h1);
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      check("bp_rsp_valid", 32'(b1.rsp_valid), 32'h1);
      check("bp_rsp_data", 32'(b1.rsp_data), 32'hF0);
      check("bp_cmd_ready", 32'(b1.cmd_ready), 32'h0);
      b1.cmd_valid = ~b1.cmd_valid; b1.cmd_op = OP_ADD; b1.cmd_a = 8'h11; b1.cmd_b = 8'h22;
      @(posedge clk); #1;
    end
    check("bp_alu_a_held", 32'(a1), 32'h0F);
    check("bp_alu_b_held", 32'(bb1), 32'hFF);
    b1.cmd_valid = 1'b0;
    b1.rsp_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_cmd_ready_after_release", 32'(b1.cmd_ready), 32'h1);
    check("bp_rsp_valid_after_release", 32'(b1.rsp_valid), 32'h0);
    send(1, OP_ADD, 8'h00, 8'h01, 1'b1, 8'hF1, 1'b0, 1, 1);

    // Settle-4 instance: operands stable for four cycles.
    send(4, OP_XOR, 8'hF0, 8'h3C, 1'b0, 8'hCC, 1'b0, 1, 0);
    for (int i = 0; i < 4; i++) begin
      check("s4_alu_a_stable", 32'(a4), 32'hF0);
      check("s4_alu_b_stable", 32'(bb4), 32'h3C);
      check("s4_alu_op_stable", 32'(op4), 32'(OP_XOR));
      check("s4_rsp_valid_low", 32'(b4.rsp_valid), 32'h0);
      @(posedge clk); #1;
    end
    wait_hs(4);

    // Reset while in DRIVE: nothing comes out, state cleared.
    send(4, OP_ADD, 8'h11, 8'h22, 1'b0, 8'h33, 1'b0, 0, 0);
    @(posedge clk); #1;
    check("mid_busy_before_rst", 32'(busy4), 32'h1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("mid_alu_a", 32'(a4), 32'h0);
    check("mid_alu_b", 32'(bb4), 32'h0);
    check("mid_alu_opcode", 32'(op4), 32'h0);
    check("mid_cmd_ready", 32'(b4.cmd_ready), 32'h1);
    check("mid_rsp_valid", 32'(b4.rsp_valid), 32'h0);
    check("mid_busy", 32'(busy4), 32'h0);
    repeat (8) @(posedge clk);
    #1;
    check("mid_no_rsp", 32'(b4.rsp_valid), 32'h0);
    send(4, OP_ADD, 8'h77, 8'h09, 1'b1, 8'h09, 1'b0, 1, 1);
    send(1, OP_OR, 8'h77, 8'h00, 1'b1, 8'h00, 1'b1, 1, 1);

`ifdef ALU_CMD_COUNT_EN
    check("d1_done_count", 32'(dc1), hs1);
    check("d4_done_count", 32'(dc4), hs4);
    check("d1_done_count_value", 32'(dc1), 32'h1);
`endif
    check("d1_scoreboard_drained", q1.size(), 0);
    check("d4_scoreboard_drained", q4.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
